// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC CPU.
// Holds the opcode values, the control-unit state encoding, the instruction
// field positions and the ALU select codes shared with the ALU.
package cpu_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned INSTR_W = 16;

  // Instruction field bit positions
  localparam int unsigned OPC_HI = 15;
  localparam int unsigned OPC_LO = 12;
  localparam int unsigned RD_HI  = 11;
  localparam int unsigned RD_LO  = 10;
  localparam int unsigned RS_HI  = 9;
  localparam int unsigned RS_LO  = 8;
  localparam int unsigned IMM_HI = 7;
  localparam int unsigned IMM_LO = 0;

  // Opcodes; 7..15 are undefined and execute as NOP
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ALU  = 4'd1;
  localparam logic [3:0] OP_LDI  = 4'd2;
  localparam logic [3:0] OP_JMP  = 4'd3;
  localparam logic [3:0] OP_JZ   = 4'd4;
  localparam logic [3:0] OP_JC   = 4'd5;
  localparam logic [3:0] OP_HALT = 4'd6;

  // ALU select codes (taken from Imm8[2:0] of an ALU instruction)
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_XOR   = 3'd4;
  localparam logic [2:0] ALU_PASSA = 3'd5;
  localparam logic [2:0] ALU_NOTA  = 3'd6;
  localparam logic [2:0] ALU_PASSB = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_e;

  function automatic logic opc_illegal(input logic [3:0] opc);
    return opc > OP_HALT;
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// General-purpose register file: NREGS x DW, two combinational read ports,
// one synchronous write port, synchronous active-high reset to zero.
// Ports:
//   clk, rst                 clock, synchronous reset
//   rd_addr_a/rd_data_a      read port A
//   rd_addr_b/rd_data_b      read port B
//   wr_en/wr_addr/wr_data    write port (lands on rising edge)
module cpu_regfile #(
  parameter int unsigned NREGS = 4,
  parameter int unsigned DW    = 8,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rd_addr_a,
  output logic [DW-1:0] rd_data_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [DW-1:0] rd_data_b,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);

  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd_data_a = regs_q[rd_addr_a];
  assign rd_data_b = regs_q[rd_addr_b];

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer of the 8-bit RISC CPU.
// Fetches 16-bit instructions over a valid handshake, reads the register
// file into the ALU operand registers, and writes ALU results and flags back.
// Ports:
//   Clk, Rst                        clock, synchronous active-high reset
//   InstrAddr/InstrReq              fetch address (PC) and request
//   InstrValid/Instr                instruction word handshake
//   AluInA/AluInB/AluSel            ALU operands and operation select
//   AluOper/AluZero                 ALU result (bit 8 carry) and zero flag
//   ZFlag/CFlag                     registered flags
//   Halted                          high while in HALT
//   IllegalOp                       one-cycle pulse on an undefined opcode
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned NREGS = 4
) (
  input  logic            Clk,
  input  logic            Rst,
  output logic [PC_W-1:0] InstrAddr,
  output logic            InstrReq,
  input  logic            InstrValid,
  input  logic [15:0]     Instr,
  output logic [7:0]      AluInA,
  output logic [7:0]      AluInB,
  output logic [2:0]      AluSel,
  input  logic [8:0]      AluOper,
  input  logic            AluZero,
  output logic            ZFlag,
  output logic            CFlag,
  output logic            Halted,
  output logic            IllegalOp
);

  localparam int unsigned RAW = $clog2(NREGS);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [7:0]      opa_q, opa_d;
  logic [7:0]      opb_q, opb_d;
  logic [2:0]      sel_q, sel_d;
  logic            z_q, z_d;
  logic            c_q, c_d;

  logic [3:0]      opc;
  logic [RAW-1:0]  rd_idx;
  logic [RAW-1:0]  rs_idx;
  logic [7:0]      imm;
  logic [7:0]      rf_a;
  logic [7:0]      rf_b;
  logic            wr_en;
  logic [7:0]      wr_data;

  assign opc    = ir_q[OPC_HI:OPC_LO];
  assign rd_idx = RAW'(ir_q[RD_HI:RD_LO]);
  assign rs_idx = RAW'(ir_q[RS_HI:RS_LO]);
  assign imm    = ir_q[IMM_HI:IMM_LO];

  cpu_regfile #(
    .NREGS (NREGS),
    .DW    (8)
  ) u_regfile (
    .clk       (Clk),
    .rst       (Rst),
    .rd_addr_a (rd_idx),
    .rd_data_a (rf_a),
    .rd_addr_b (rs_idx),
    .rd_data_b (rf_b),
    .wr_en     (wr_en),
    .wr_addr   (rd_idx),
    .wr_data   (wr_data)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sel_d   = sel_q;
    z_d     = z_q;
    c_d     = c_q;
    wr_en   = 1'b0;
    wr_data = imm;

    unique case (state_q)
      S_FETCH: begin
        if (InstrValid) begin
          ir_d    = Instr;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Operands are only captured for instructions that reach EXECUTE so the
        // ALU-facing outputs keep their last value across jumps and NOPs.
        case (opc)
          OP_HALT: state_d = S_HALT;
          OP_JMP: begin
            pc_d    = PC_W'(imm);
            state_d = S_FETCH;
          end
          OP_JZ: begin
            if (z_q) pc_d = PC_W'(imm);
            state_d = S_FETCH;
          end
          OP_JC: begin
            if (c_q) pc_d = PC_W'(imm);
            state_d = S_FETCH;
          end
          OP_LDI: begin
            opa_d   = rf_a;
            opb_d   = rf_b;
            state_d = S_EXECUTE;
          end
          OP_ALU: begin
            opa_d   = rf_a;
            opb_d   = rf_b;
            sel_d   = imm[2:0];
            state_d = S_EXECUTE;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_EXECUTE: begin
        if (opc == OP_LDI) begin
          wr_en   = 1'b1;
          wr_data = imm;
          state_d = S_FETCH;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        wr_en   = 1'b1;
        wr_data = AluOper[7:0];
        c_d     = AluOper[8];
        z_d     = AluZero;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sel_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sel_q   <= sel_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  // Status strobes are masked while Rst is high so the reset cycle itself
  // shows no request, halt or illegal indication.
  assign InstrAddr = pc_q;
  assign InstrReq  = (state_q == S_FETCH) && !Rst;
  assign Halted    = (state_q == S_HALT) && !Rst;
  assign IllegalOp = (state_q == S_DECODE) && opc_illegal(opc) && !Rst;
  assign AluInA    = opa_q;
  assign AluInB    = opb_q;
  assign AluSel    = sel_q;
  assign ZFlag     = z_q;
  assign CFlag     = c_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: directed vector table, reset and
// halt sequences, and random instruction streams checked against an
// instruction-level model of the CPU.
module tb_cpu_control_unit;
  import cpu_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [7:0]  InstrAddr;
  logic        InstrReq;
  logic        InstrValid;
  logic [15:0] Instr;
  logic [7:0]  AluInA, AluInB;
  logic [2:0]  AluSel;
  logic [8:0]  AluOper;
  logic        AluZero;
  logic        ZFlag, CFlag, Halted, IllegalOp;

  int n_checks = 0;
  int n_errors = 0;

  cpu_control_unit #(
    .PC_W  (8),
    .NREGS (4)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .InstrAddr  (InstrAddr),
    .InstrReq   (InstrReq),
    .InstrValid (InstrValid),
    .Instr      (Instr),
    .AluInA     (AluInA),
    .AluInB     (AluInB),
    .AluSel     (AluSel),
    .AluOper    (AluOper),
    .AluZero    (AluZero),
    .ZFlag      (ZFlag),
    .CFlag      (CFlag),
    .Halted     (Halted),
    .IllegalOp  (IllegalOp)
  );

  always #5 Clk = ~Clk;

  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] sel);
    case (sel)
      ALU_ADD:   return {1'b0, a} + {1'b0, b};
      ALU_SUB:   return {1'b0, a} - {1'b0, b};
      ALU_AND:   return {1'b0, a & b};
      ALU_OR:    return {1'b0, a | b};
      ALU_XOR:   return {1'b0, a ^ b};
      ALU_PASSA: return {1'b0, a};
      ALU_NOTA:  return {1'b0, ~a};
      default:   return {1'b0, b};
    endcase
  endfunction

  // External ALU the control unit drives
  always_comb begin
    AluOper = alu_f(AluInA, AluInB, AluSel);
    AluZero = (AluOper[7:0] == 8'h00);
  end

  // Instruction-level model
  logic [7:0] m_reg [4];
  logic [7:0] m_pc;
  bit         m_z, m_c;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    m_pc = 8'h00;
    m_z  = 1'b0;
    m_c  = 1'b0;
  endtask

  task automatic model_step(input logic [15:0] ins, output int lat,
                            output logic [7:0] ea, output logic [7:0] eb,
                            output bit ill, output bit hlt);
    logic [3:0] op;
    int         rd, rs;
    logic [7:0] imm;
    logic [8:0] r;
    op  = ins[15:12];
    rd  = int'(ins[11:10]);
    rs  = int'(ins[9:8]);
    imm = ins[7:0];
    ea  = m_reg[rd];
    eb  = m_reg[rs];
    ill = 1'b0;
    hlt = 1'b0;
    lat = 2;
    m_pc = m_pc + 8'd1;
    case (op)
      4'd0: lat = 2;
      4'd1: begin
        r = alu_f(ea, eb, imm[2:0]);
        m_reg[rd] = r[7:0];
        m_c = r[8];
        m_z = (r[7:0] == 8'h00);
        lat = 4;
      end
      4'd2: begin m_reg[rd] = imm; lat = 3; end
      4'd3: m_pc = imm;
      4'd4: if (m_z) m_pc = imm;
      4'd5: if (m_c) m_pc = imm;
      4'd6: hlt = 1'b1;
      default: ill = 1'b1;
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Runs one instruction through the handshake starting from FETCH and checks
  // the stall behaviour, operands, latency and resulting architectural state.
  task automatic exec_check(input logic [15:0] ins, input int waitc, input logic [7:0] pre_pc,
                            input int elat, input logic [7:0] epc, input bit ez, input bit ec,
                            input logic [7:0] ea, input logic [7:0] eb, input bit eill,
                            input bit ehalt);
    int cyc;
    int ill_cnt;
    chk("fetch_req", InstrReq, 1);
    chk("fetch_addr", InstrAddr, pre_pc);
    for (int w = 0; w < waitc; w++) begin
      InstrValid = 1'b0;
      Instr      = 16'($urandom);
      @(posedge Clk); #1;
      chk("stall_req", InstrReq, 1);
      chk("stall_addr", InstrAddr, pre_pc);
    end
    InstrValid = 1'b1;
    Instr      = ins;
    @(posedge Clk); #1;
    InstrValid = 1'b0;
    Instr      = 16'($urandom);
    cyc     = 1;
    ill_cnt = int'(IllegalOp);
    while (!InstrReq && !Halted && cyc < 10) begin
      if (ins[15:12] == OP_ALU && cyc == 2) begin
        chk("alu_in_a", AluInA, ea);
        chk("alu_in_b", AluInB, eb);
        chk("alu_sel", AluSel, ins[2:0]);
      end
      @(posedge Clk); #1;
      cyc++;
      ill_cnt += int'(IllegalOp);
    end
    chk("latency", cyc, elat);
    chk("next_addr", InstrAddr, epc);
    chk("zflag", ZFlag, ez);
    chk("cflag", CFlag, ec);
    chk("illegal_pulses", ill_cnt, eill);
    chk("halted", Halted, ehalt);
  endtask

  task automatic run_model(input logic [15:0] ins, input int waitc);
    logic [7:0] pre, ea, eb;
    int         lat;
    bit         ill, hlt;
    pre = m_pc;
    model_step(ins, lat, ea, eb, ill, hlt);
    exec_check(ins, waitc, pre, lat, m_pc, m_z, m_c, ea, eb, ill, hlt);
  endtask

  typedef struct {
    logic [15:0] ins;
    int          waitc;
    int          lat;
    logic [7:0]  pc;
    bit          z;
    bit          c;
    logic [7:0]  a;
    logic [7:0]  b;
    bit          ill;
  } vec_t;

  vec_t vecs [18];

  initial begin
    logic [7:0] prev;
    int         lat_d;
    logic [7:0] ea_d, eb_d;
    bit         ill_d, hlt_d;

    vecs[0]  = '{16'h2405, 0, 3, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0}; // LDI R1,05
    vecs[1]  = '{16'h1502, 0, 4, 8'h02, 1'b0, 1'b0, 8'h05, 8'h05, 1'b0}; // AND R1,R1
    vecs[2]  = '{16'h20FF, 0, 3, 8'h03, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0}; // LDI R0,FF
    vecs[3]  = '{16'h2401, 2, 3, 8'h04, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0}; // LDI R1,01
    vecs[4]  = '{16'h1100, 0, 4, 8'h05, 1'b1, 1'b1, 8'hFF, 8'h01, 1'b0}; // ADD R0,R1
    vecs[5]  = '{16'h1002, 0, 4, 8'h06, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0}; // AND R0,R0
    vecs[6]  = '{16'h4040, 0, 2, 8'h40, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0}; // JZ 40 taken
    vecs[7]  = '{16'h5080, 0, 2, 8'h41, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0}; // JC 80 not taken
    vecs[8]  = '{16'h0000, 5, 2, 8'h42, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0}; // NOP, 5-cycle stall
    vecs[9]  = '{16'hA5FF, 0, 2, 8'h43, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1}; // illegal 0xA
    vecs[10] = '{16'h1502, 0, 4, 8'h44, 1'b0, 1'b0, 8'h01, 8'h01, 1'b0}; // AND R1,R1
    vecs[11] = '{16'h30FF, 0, 2, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0}; // JMP FF
    vecs[12] = '{16'h2880, 0, 3, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0}; // LDI R2,80 @FF
    vecs[13] = '{16'h5020, 0, 2, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0}; // JC not taken
    vecs[14] = '{16'h4030, 1, 2, 8'h02, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0}; // JZ not taken
    vecs[15] = '{16'h1A00, 0, 4, 8'h03, 1'b1, 1'b1, 8'h80, 8'h80, 1'b0}; // ADD R2,R2
    vecs[16] = '{16'h5080, 0, 2, 8'h80, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0}; // JC 80 taken
    vecs[17] = '{16'h1101, 0, 4, 8'h81, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0}; // SUB R0,R1

    Rst        = 1'b1;
    InstrValid = 1'b0;
    Instr      = 16'h0000;
    model_reset();
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("rst_req", InstrReq, 0);
    chk("rst_addr", InstrAddr, 0);
    chk("rst_alu_a", AluInA, 0);
    chk("rst_alu_b", AluInB, 0);
    chk("rst_alu_sel", AluSel, 0);
    chk("rst_flags", {ZFlag, CFlag, Halted, IllegalOp}, 0);
    Rst = 1'b0;
    #1;

    // Directed vectors
    prev = 8'h00;
    for (int i = 0; i < 18; i++) begin
      model_step(vecs[i].ins, lat_d, ea_d, eb_d, ill_d, hlt_d);
      exec_check(vecs[i].ins, vecs[i].waitc, prev, vecs[i].lat, vecs[i].pc,
                 vecs[i].z, vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].ill, 1'b0);
      prev = vecs[i].pc;
    end

    // Reset landing on the WRITEBACK edge of an ALU instruction
    run_model(16'h20FF, 0);
    run_model(16'h2401, 0);
    InstrValid = 1'b1;
    Instr      = 16'h1100;
    @(posedge Clk); #1;
    InstrValid = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("wb_req", InstrReq, 0);
    Rst = 1'b1;
    @(posedge Clk); #1;
    chk("rst_wb_req", InstrReq, 0);
    Rst = 1'b0;
    #1;
    model_reset();
    chk("rst_wb_fetch", InstrReq, 1);
    chk("rst_wb_addr", InstrAddr, 0);
    chk("rst_wb_z", ZFlag, 0);
    chk("rst_wb_c", CFlag, 0);
    run_model(16'h1100, 0);
    run_model(16'h1002, 0);

    // Random instruction stream against the model
    for (int i = 0; i < 200; i++) begin
      int unsigned r;
      logic [3:0]  op;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: op = OP_ALU;
        4, 5:       op = OP_LDI;
        6:          op = ($urandom_range(0, 1) == 0) ? OP_JZ : OP_JC;
        7:          op = OP_JMP;
        8:          op = OP_NOP;
        default:    op = 4'($urandom_range(7, 15));
      endcase
      run_model({op, 12'($urandom)}, ($urandom_range(0, 3) == 0) ? 2 : 0);
    end

    // HALT holds until reset, ignoring offered instructions
    run_model(16'h6000, 0);
    for (int i = 0; i < 4; i++) begin
      InstrValid = 1'b1;
      Instr      = 16'($urandom);
      @(posedge Clk); #1;
      chk("halt_hold", {Halted, InstrReq}, 2'b10);
    end
    InstrValid = 1'b0;
    Rst = 1'b1;
    @(posedge Clk); #1;
    chk("halt_rst_halted", Halted, 0);
    chk("halt_rst_addr", InstrAddr, 0);
    chk("halt_rst_alu", {AluInA, AluInB, AluSel}, 0);
    Rst = 1'b0;
    #1;
    chk("halt_rst_fetch", InstrReq, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
